noc_rx_dispatch: RTL and testbench
==================================

Name: noc_rx_dispatch

Overview:
- Ingress stage between the mesh router's local ejection port and the solver core.
- Buffers incoming noc_packet_t words (80 bits) in a small FIFO.
- Filters unwanted packets and dispatches the rest, by msg_type, onto three core-side channels: divergence literal, imported clause, neighbour status.
- Downstream consumers are the decision/assumption unit (MSG_DIVERGE) and the clause-import unit (MSG_CLAUSE).

Parameters:
- FIFO_DEPTH, 8, packet buffer entries; power of two, ≥2.
- LBD_THRESH, 6, clauses with quality_metric > LBD_THRESH are discarded.
- CORE_ID, 0, this core's id (CORE_ID_W bits); used for loopback suppression.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  router presents packet
- in_ready  out  1  FIFO not full
- in_pkt  in  80  noc_packet_t {msg_type, payload, quality_metric, src_id, virtual_channel}
- div_valid  out  1  divergence literal available
- div_ready  in  1  consumer accepts literal
- div_lit  out  32  signed literal, payload[31:0]
- cls_valid  out  1  clause pair available
- cls_ready  in  1  consumer accepts clause
- cls_lit0  out  32  payload[31:0]
- cls_lit1  out  32  payload[63:32]
- cls_lbd  out  8  quality_metric
- stat_pulse  out  1  one-cycle status strobe
- stat_src  out  4  src_id of status packet
- stat_code  out  2  payload[1:0]: 0 idle, 1 busy, 2 sat, 3 unsat
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
- drop_cnt  out  16  discarded-packet counter

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, in_ready=1, all valids=0, stat_pulse=0, data outputs=0, drop_cnt=0, FSM=IDLE.
- Ingress: push when in_valid & in_ready. in_ready = (fifo_count != FIFO_DEPTH), taken from registered count only; it does not depend on same-cycle pop.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: count is unchanged.
- FSM IDLE: if the FIFO is non-empty, pop the head and classify it in the same cycle, then:
  - Drop the packet (drop_cnt +1, stay IDLE) if src_id==CORE_ID, or msg_type==2'b11, or (MSG_CLAUSE and quality_metric > LBD_THRESH).
  - MSG_STATUS: register stat_src and stat_code; stat_pulse=1 in the next cycle only; stay IDLE.
  - MSG_DIVERGE: load div_lit, set div_valid next cycle, go to WAIT_DIV.
  - MSG_CLAUSE: load cls_lit0, cls_lit1, cls_lbd, set cls_valid next cycle, go to WAIT_CLS.
- WAIT_DIV / WAIT_CLS: valid and data are held stable until ready is sampled high. On the handshake, drop valid and return to IDLE; no pop occurs in the handshake cycle.
- Throughput: at most one packet is popped per cycle in IDLE. Minimum latency from push at cycle N to valid/stat_pulse is cycle N+2.
- Ready may be asserted before valid; this has no effect.
- virtual_channel is ignored.
- drop_cnt saturates at 16'hFFFF.
- Reset mid-operation (packet held in WAIT state or FIFO non-empty): all contents are discarded and there is no spurious pulse after release.

Optional Feature:
- Macro NOC_RX_DROP_CNT_EN.
  - Defined: drop_cnt counts as described above.
  - Undefined: the counter logic is removed and drop_cnt is tied to 16'h0000. Filtering behaviour is identical in both builds.

Test Plan:
- Basic divergence: push DIVERGE, src=1, payload[31:0]=-5, div_ready=1 → div_valid for exactly 1 cycle at N+2 with div_lit=32'hFFFFFFFB; fifo_count returns to 0.
- Clause filter with LBD_THRESH=6: push CLAUSE lbd=6 lits (12,-7), then CLAUSE lbd=7 → first delivered with cls_lit0=12, cls_lit1=-7, cls_lbd=6; second dropped, drop_cnt=1 (0 without macro).
- Loopback and reserved type: push src_id=CORE_ID DIVERGE, then msg_type=3 → no valid or pulse, drop_cnt=2.
- Backpressure/full: hold div_ready=0 and push 9 DIVERGE packets (lits 1..9) → first goes to WAIT_DIV, in_ready deasserts once fifo_count=8; release ready → lits 1..9 delivered in order, each held stable while stalled.
- Status: push STATUS src=3 payload=2 → stat_pulse high one cycle with stat_src=3, stat_code=2; no div/cls activity.
- Async reset while cls_valid held with 3 queued packets → all outputs 0 immediately; after release, no output activity until a new push.

Source files
------------

// File: rtl/noc_rx_dispatch.sv
// NoC ejection-port ingress: packet FIFO, filter and per-type dispatch to the core.
// Optional NOC_RX_DROP_CNT_EN enables the discarded-packet counter on drop_cnt.
module noc_rx_dispatch #(
    parameter int         FIFO_DEPTH = 8,
    parameter int         LBD_THRESH = 6,
    parameter logic [3:0] CORE_ID    = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [79:0]                   in_pkt,
    output logic                          div_valid,
    input  logic                          div_ready,
    output logic [31:0]                   div_lit,
    output logic                          cls_valid,
    input  logic                          cls_ready,
    output logic [31:0]                   cls_lit0,
    output logic [31:0]                   cls_lit1,
    output logic [7:0]                    cls_lbd,
    output logic                          stat_pulse,
    output logic [3:0]                    stat_src,
    output logic [1:0]                    stat_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] MSG_DIVERGE = 2'd0;
    localparam logic [1:0] MSG_CLAUSE  = 2'd1;
    localparam logic [1:0] MSG_STATUS  = 2'd2;
    localparam logic [7:0] LBD_MAX     = 8'(LBD_THRESH);

    typedef enum logic [1:0] {IDLE, WAIT_DIV, WAIT_CLS} state_t;

    logic [77:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    state_t        state;

    logic          push;
    logic          pop;
    logic          drop;
    logic [77:0]   head;
    logic [1:0]    h_type;
    logic [63:0]   h_pay;
    logic [7:0]    h_lbd;
    logic [3:0]    h_src;
    logic          unused_vc;

    // virtual_channel carries no meaning here and is never stored
    assign unused_vc  = ^in_pkt[1:0];

    assign in_ready   = (count != CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign push       = in_valid & in_ready;
    assign pop        = (state == IDLE) && (count != '0);

    assign head   = mem[rptr];
    assign h_type = head[77:76];
    assign h_pay  = head[75:12];
    assign h_lbd  = head[11:4];
    assign h_src  = head[3:0];

    assign drop = pop & ((h_src == CORE_ID) ||
                         (h_type == 2'b11) ||
                         ((h_type == MSG_CLAUSE) && (h_lbd > LBD_MAX)));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_pkt[79:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_valid  <= 1'b0;
            div_lit    <= '0;
            cls_valid  <= 1'b0;
            cls_lit0   <= '0;
            cls_lit1   <= '0;
            cls_lbd    <= '0;
            stat_pulse <= 1'b0;
            stat_src   <= '0;
            stat_code  <= '0;
        end else begin
            stat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop && !drop) begin
                        case (h_type)
                            MSG_DIVERGE: begin
                                div_lit   <= h_pay[31:0];
                                div_valid <= 1'b1;
                                state     <= WAIT_DIV;
                            end
                            MSG_CLAUSE: begin
                                cls_lit0  <= h_pay[31:0];
                                cls_lit1  <= h_pay[63:32];
                                cls_lbd   <= h_lbd;
                                cls_valid <= 1'b1;
                                state     <= WAIT_CLS;
                            end
                            MSG_STATUS: begin
                                stat_src   <= h_src;
                                stat_code  <= h_pay[1:0];
                                stat_pulse <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                WAIT_DIV: begin
                    if (div_ready) begin
                        div_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT_CLS: begin
                    if (cls_ready) begin
                        cls_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOC_RX_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_rx_dispatch.sv
// Randomised and directed bench for noc_rx_dispatch against a queue-based
// model of the filter/dispatch rules.
module tb_noc_rx_dispatch;

    localparam logic [3:0] CORE_ID = 4'd0;
    localparam int         LBD     = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_pkt;
    logic        div_valid;
    logic        div_ready;
    logic [31:0] div_lit;
    logic        cls_valid;
    logic        cls_ready;
    logic [31:0] cls_lit0;
    logic [31:0] cls_lit1;
    logic [7:0]  cls_lbd;
    logic        stat_pulse;
    logic [3:0]  stat_src;
    logic [1:0]  stat_code;
    logic [3:0]  fifo_count;
    logic [15:0] drop_cnt;

    noc_rx_dispatch #(.FIFO_DEPTH(8), .LBD_THRESH(LBD), .CORE_ID(CORE_ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .div_valid(div_valid), .div_ready(div_ready), .div_lit(div_lit),
        .cls_valid(cls_valid), .cls_ready(cls_ready),
        .cls_lit0(cls_lit0), .cls_lit1(cls_lit1), .cls_lbd(cls_lbd),
        .stat_pulse(stat_pulse), .stat_src(stat_src), .stat_code(stat_code),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_drops = 0;
    int          stall_viol = 0;
    logic [73:0] expq[$];
    logic [73:0] obsq[$];
    logic        pd_stall = 1'b0;
    logic [31:0] pd_lit;
    logic        pc_stall = 1'b0;
    logic [71:0] pc_dat;

    // event = {kind, data}: 0 literal, 1 clause {lbd,lit1,lit0}, 2 status
    always @(negedge clk) begin
        if (!rst_n) begin
            pd_stall = 1'b0;
            pc_stall = 1'b0;
        end else begin
            if (div_valid && div_ready)
                obsq.push_back({2'd0, 40'd0, div_lit});
            if (cls_valid && cls_ready)
                obsq.push_back({2'd1, cls_lbd, cls_lit1, cls_lit0});
            if (stat_pulse)
                obsq.push_back({2'd2, 66'd0, stat_src, stat_code});
            if (div_valid && pd_stall && div_lit !== pd_lit)
                stall_viol++;
            if (cls_valid && pc_stall && {cls_lbd, cls_lit1, cls_lit0} !== pc_dat)
                stall_viol++;
            pd_stall = div_valid && !div_ready;
            pd_lit   = div_lit;
            pc_stall = cls_valid && !cls_ready;
            pc_dat   = {cls_lbd, cls_lit1, cls_lit0};
        end
    end

    function automatic logic [79:0] mk(input logic [1:0] t, input logic [63:0] pl,
                                       input logic [7:0] q, input logic [3:0] s);
        logic [1:0] vc;
        vc = 2'($urandom);
        return {t, pl, q, s, vc};
    endfunction

    function automatic void model_push(input logic [79:0] p);
        logic [1:0]  t;
        logic [63:0] pl;
        logic [7:0]  q;
        logic [3:0]  s;
        t  = p[79:78];
        pl = p[77:14];
        q  = p[13:6];
        s  = p[5:2];
        if (s == CORE_ID || t == 2'd3 || (t == 2'd1 && int'(q) > LBD))
            exp_drops++;
        else if (t == 2'd0)
            expq.push_back({2'd0, 40'd0, pl[31:0]});
        else if (t == 2'd1)
            expq.push_back({2'd1, q, pl});
        else
            expq.push_back({2'd2, 66'd0, s, pl[1:0]});
    endfunction

    function automatic logic [15:0] exp_dc();
`ifdef NOC_RX_DROP_CNT_EN
        return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic send(input logic [79:0] p);
        int n = 0;
        in_pkt   = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_accept: in_ready=%b required 1", in_ready);
        end else begin
            model_push(p);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (obsq.size() < expq.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_events(input string name);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_bad++;
            $display("FAIL %s_events: got %0d events, required %0d",
                     name, obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            n_cmp++;
            if (obsq[i] !== expq[i]) begin
                n_bad++;
                $display("FAIL %s_ev%0d: got %h required %h", name, i, obsq[i], expq[i]);
            end
        end
        n_cmp++;
        if (fifo_count !== 4'd0 || drop_cnt !== exp_dc()) begin
            n_bad++;
            $display("FAIL %s_idle: count=%0d drop=%0d required 0 / %0d",
                     name, fifo_count, drop_cnt, exp_dc());
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pkt    = '0;
        div_ready = 1'b0;
        cls_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, div_valid, cls_valid, stat_pulse, fifo_count, drop_cnt} !== {1'b1, 23'd0}) begin
            n_bad++;
            $display("FAIL reset_ctl: rdy=%b dv=%b cv=%b sp=%b cnt=%0d drop=%0d required 1/0/0/0/0/0",
                     in_ready, div_valid, cls_valid, stat_pulse, fifo_count, drop_cnt);
        end
        n_cmp++;
        if ({div_lit, cls_lit0, cls_lit1, cls_lbd, stat_src, stat_code} !== 110'd0) begin
            n_bad++;
            $display("FAIL reset_data: %h %h %h %h %h %h required all 0",
                     div_lit, cls_lit0, cls_lit1, cls_lbd, stat_src, stat_code);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_diverge();
        div_ready = 1'b1;
        send(mk(2'd0, {32'd0, 32'hFFFFFFFB}, 8'd0, 4'd1));
        @(negedge clk);
        n_cmp++;
        if (div_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL div_early: div_valid=%b required 0", div_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (div_valid !== 1'b1 || div_lit !== 32'hFFFFFFFB) begin
            n_bad++;
            $display("FAIL div_n2: valid=%b lit=%h required 1 FFFFFFFB", div_valid, div_lit);
        end
        @(negedge clk);
        n_cmp++;
        if (div_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL div_one_cycle: div_valid=%b required 0", div_valid);
        end
        @(posedge clk);
        #1;
        wait_drain();
        compare_events("diverge");
    endtask

    task automatic test_clause_filter();
        cls_ready = 1'b1;
        send(mk(2'd1, {32'hFFFFFFF9, 32'd12}, 8'd6, 4'd2));
        send(mk(2'd1, {32'd3, 32'd4}, 8'd7, 4'd2));
        wait_drain();
        compare_events("clause");
    endtask

    task automatic test_loopback();
        send(mk(2'd0, 64'd77, 8'd0, CORE_ID));
        send(mk(2'd3, 64'd78, 8'd0, 4'd5));
        wait_drain();
        compare_events("loopback");
    endtask

    task automatic test_backpressure();
        div_ready = 1'b0;
        for (int i = 1; i <= 9; i++)
            send(mk(2'd0, 64'(i), 8'd0, 4'd1));
        n_cmp++;
        if (fifo_count !== 4'd8 || in_ready !== 1'b0 || div_valid !== 1'b1 || div_lit !== 32'd1) begin
            n_bad++;
            $display("FAIL bp_full: cnt=%0d rdy=%b dv=%b lit=%0d required 8 0 1 1",
                     fifo_count, in_ready, div_valid, div_lit);
        end
        repeat (5) @(posedge clk);
        #1 div_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (stall_viol !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stall_viol);
        end
        compare_events("backpressure");
    endtask

    task automatic test_status();
        send(mk(2'd2, 64'd2, 8'd0, 4'd3));
        @(negedge clk);
        n_cmp++;
        if (stat_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL stat_early: pulse=%b required 0", stat_pulse);
        end
        @(negedge clk);
        n_cmp++;
        if ({stat_pulse, stat_src, stat_code, div_valid, cls_valid} !== {1'b1, 4'd3, 2'd2, 2'b00}) begin
            n_bad++;
            $display("FAIL stat_n2: pulse=%b src=%0d code=%0d dv=%b cv=%b required 1 3 2 0 0",
                     stat_pulse, stat_src, stat_code, div_valid, cls_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (stat_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL stat_width: pulse=%b required 0", stat_pulse);
        end
        @(posedge clk);
        #1;
        wait_drain();
        compare_events("status");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    send(mk(2'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 9)),
                            4'($urandom_range(0, 3))));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    div_ready = 1'($urandom);
                    cls_ready = 1'($urandom);
                end
            end
        join
        div_ready = 1'b1;
        cls_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (stall_viol !== 0) begin
            n_bad++;
            $display("FAIL rand_stable: %0d changes while stalled, required 0", stall_viol);
        end
        compare_events("random");
    endtask

    task automatic test_reset_mid();
        cls_ready = 1'b0;
        send(mk(2'd1, {32'd5, 32'd6}, 8'd3, 4'd1));
        for (int i = 0; i < 3; i++)
            send(mk(2'd0, 64'(100 + i), 8'd0, 4'd2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, div_valid, cls_valid, stat_pulse, fifo_count, drop_cnt, cls_lit0, cls_lbd}
                !== {1'b1, 63'd0}) begin
            n_bad++;
            $display("FAIL rst_mid: rdy=%b dv=%b cv=%b sp=%b cnt=%0d drop=%0d l0=%h lbd=%h required 1 then 0s",
                     in_ready, div_valid, cls_valid, stat_pulse, fifo_count, drop_cnt, cls_lit0, cls_lbd);
        end
        expq.delete();
        obsq.delete();
        exp_drops = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cls_ready = 1'b1;
        div_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (obsq.size() != 0) begin
            n_bad++;
            $display("FAIL rst_quiet: %0d events after release, required 0", obsq.size());
        end
        send(mk(2'd0, 64'd42, 8'd0, 4'd7));
        wait_drain();
        compare_events("post_reset");
    endtask

    initial begin
        test_reset();
        test_diverge();
        test_clause_filter();
        test_loopback();
        test_backpressure();
        test_status();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
